// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core/host arbiter for a shared single-port data RAM with host anti-starvation
module dmem_arbiter #(
   parameter int AW            = 10,
   parameter int HOST_MAX_WAIT = 4
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [31:0]   i_cpu_daddr,
   input  logic [31:0]   i_cpu_ddata,
   input  logic          i_cpu_dwe,
   input  logic          i_cpu_dre,
   output logic [31:0]   o_cpu_rdata,
   output logic          o_cpu_hlt,
   input  logic          i_h_req,
   input  logic          i_h_we,
   input  logic [31:0]   i_h_addr,
   input  logic [31:0]   i_h_wdata,
   output logic          o_h_gnt,
   output logic          o_h_rvalid,
   output logic [31:0]   o_h_rdata,
   output logic [AW-1:0] o_ram_addr,
   output logic          o_ram_we,
   output logic [31:0]   o_ram_wdata,
   input  logic [31:0]   i_ram_rdata
);
   typedef enum logic {IDLE, RD_WAIT} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_HOST} own_t;
   state_t        state;
   own_t          rd_own;
   logic [7:0]    wait_cnt;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic          rd_wait, cpu_any, cpu_req, host_win, cpu_gnt, cpu_rd_gnt, wait_full;
   logic          unused_bits;
   assign unused_bits = ^{i_cpu_daddr[31:AW+2], i_cpu_daddr[1:0], i_h_addr[31:AW+2], i_h_addr[1:0]};
   always_comb begin
      rd_wait     = state == RD_WAIT;
      cpu_any     = i_cpu_dre | i_cpu_dwe;
      cpu_req     = cpu_any & ~rd_wait;
      wait_full   = wait_cnt == 8'(HOST_MAX_WAIT);
      host_win    = ~i_rst & i_h_req & (~cpu_req | wait_full);
      cpu_gnt     = ~i_rst & cpu_req & ~host_win;
      cpu_rd_gnt  = cpu_gnt & ~i_cpu_dwe;
      o_h_gnt     = host_win;
      o_ram_we    = host_win ? i_h_we : cpu_gnt & i_cpu_dwe;
      o_ram_addr  = host_win ? i_h_addr[AW+1:2] : cpu_gnt ? i_cpu_daddr[AW+1:2] : addr_q;
      o_ram_wdata = host_win ? i_h_wdata : cpu_gnt ? i_cpu_ddata : wdata_q;
      // a granted core write completes this cycle; anything else pending stalls until RD_WAIT
      o_cpu_hlt   = ~i_rst & cpu_any & ~(cpu_gnt & i_cpu_dwe) & ~rd_wait;
      o_cpu_rdata = (rd_wait & ~i_rst) ? i_ram_rdata : '0;
      o_h_rvalid  = (rd_own == OWN_HOST) & ~i_rst;
      o_h_rdata   = o_h_rvalid ? i_ram_rdata : '0;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= IDLE;
         rd_own   <= OWN_NONE;
         wait_cnt <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state    <= cpu_rd_gnt ? RD_WAIT : IDLE;
         rd_own   <= (host_win & ~i_h_we) ? OWN_HOST : cpu_rd_gnt ? OWN_CPU : OWN_NONE;
         wait_cnt <= (~i_h_req | host_win) ? 8'd0 : wait_full ? wait_cnt : wait_cnt + 8'd1;
         if (host_win | cpu_gnt) begin
            addr_q  <= o_ram_addr;
            wdata_q <= o_ram_wdata;
         end
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter with a behavioral RAM
module tb_dmem_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cpu_daddr = '0, cpu_ddata = '0, cpu_rdata;
   logic        cpu_dwe = 1'b0, cpu_dre = 1'b0, cpu_hlt;
   logic        h_req = 1'b0, h_we = 1'b0, h_gnt, h_rvalid;
   logic [31:0] h_addr = '0, h_wdata = '0, h_rdata;
   logic [9:0]  ram_addr;
   logic        ram_we;
   logic [31:0] ram_wdata, ram_rdata;
   logic [31:0] mem [1024];
   logic        mem_init = 1'b1;
   logic [31:0] host_q[$], cpu_q[$];
   int          errors = 0, checks = 0;
   always #5 clk = ~clk;
   dmem_arbiter #(.AW(10), .HOST_MAX_WAIT(4)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_cpu_daddr(cpu_daddr), .i_cpu_ddata(cpu_ddata), .i_cpu_dwe(cpu_dwe), .i_cpu_dre(cpu_dre),
      .o_cpu_rdata(cpu_rdata), .o_cpu_hlt(cpu_hlt),
      .i_h_req(h_req), .i_h_we(h_we), .i_h_addr(h_addr), .i_h_wdata(h_wdata),
      .o_h_gnt(h_gnt), .o_h_rvalid(h_rvalid), .o_h_rdata(h_rdata),
      .o_ram_addr(ram_addr), .o_ram_we(ram_we), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
   );
   // synchronous RAM, read-before-write, one-cycle read latency
   always @(posedge clk) begin
      if (mem_init) for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      else if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic settle();
      @(negedge clk);
   endtask
   always @(negedge clk) begin
      if (h_rvalid) begin
         if (host_q.size() == 0) chk("h_rvalid_unexpected", 32'd1, 32'd0);
         else chk("h_rdata", h_rdata, host_q.pop_front());
      end
   end
   initial begin
      logic exp_g;
      h_req = 1'b1; h_addr = 32'h8;
      for (int k = 0; k < 10; k++) begin
         settle();
         chk("rst_h_gnt", h_gnt, 0);
         chk("rst_ram_we", ram_we, 0);
         chk("rst_h_rvalid", h_rvalid, 0);
         chk("rst_cpu_hlt", cpu_hlt, 0);
         chk("rst_ram_addr", ram_addr, 0);
      end
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_h_rdata", h_rdata, 0);
      tick(); rst = 1'b0; mem_init = 1'b0;
      settle();
      chk("post_rst_h_gnt", h_gnt, 1);
      host_q.push_back(32'hA500_0002);
      tick(); h_req = 1'b0;
      settle();
      chk("post_rst_rvalid", h_rvalid, 1);
      tick(); cpu_dwe = 1'b1; cpu_daddr = 32'h40; cpu_ddata = 32'hDEAD_BEEF;
      settle();
      chk("cw_hlt", cpu_hlt, 0);
      chk("cw_addr", ram_addr, 32'h10);
      chk("cw_we", ram_we, 1);
      chk("cw_wdata", ram_wdata, 32'hDEAD_BEEF);
      tick(); cpu_dwe = 1'b0;
      settle();
      chk("cw_we_off", ram_we, 0);
      tick(); cpu_dre = 1'b1; cpu_q.push_back(32'hDEAD_BEEF);
      settle();
      chk("cr_hlt1", cpu_hlt, 1);
      chk("cr_we", ram_we, 0);
      tick();
      settle();
      chk("cr_hlt0", cpu_hlt, 0);
      chk("cr_rdata", cpu_rdata, cpu_q.pop_front());
      tick(); cpu_dre = 1'b0;
      settle();
      chk("idle_hlt", cpu_hlt, 0);
      for (int k = 0; k < 15; k++) begin
         tick();
         if (k == 0) begin
            cpu_dwe = 1'b1; cpu_daddr = 32'h100; cpu_ddata = 32'h1111_2222;
            h_req = 1'b1; h_we = 1'b0; h_addr = 32'h20;
         end
         settle();
         exp_g = (k % 5) == 4;
         chk($sformatf("cont_gnt_%0d", k), h_gnt, exp_g);
         chk($sformatf("cont_hlt_%0d", k), cpu_hlt, exp_g);
         chk($sformatf("cont_we_%0d", k), ram_we, !exp_g);
         if (exp_g) host_q.push_back(32'hA500_0008);
      end
      tick(); cpu_dwe = 1'b0; h_req = 1'b0;
      settle();
      tick();
      cpu_dre = 1'b1; cpu_daddr = 32'h40; h_req = 1'b1; h_we = 1'b0; h_addr = 32'h24;
      cpu_q.push_back(32'hDEAD_BEEF);
      settle();
      chk("both_t_gnt", h_gnt, 0);
      chk("both_t_hlt", cpu_hlt, 1);
      chk("both_t_addr", ram_addr, 32'h10);
      tick();
      settle();
      chk("both_t1_gnt", h_gnt, 1);
      chk("both_t1_hlt", cpu_hlt, 0);
      chk("both_t1_rdata", cpu_rdata, cpu_q.pop_front());
      chk("both_t1_addr", ram_addr, 32'h9);
      host_q.push_back(32'hA500_0009);
      tick(); cpu_dre = 1'b0; h_req = 1'b0;
      settle();
      chk("both_t2_rvalid", h_rvalid, 1);
      chk("both_t2_cpu_rdata", cpu_rdata, 0);
      tick(); h_req = 1'b1; h_addr = 32'hC;
      settle();
      chk("mid_gnt", h_gnt, 1);
      tick(); rst = 1'b1; h_req = 1'b0;
      settle();
      chk("mid_rvalid", h_rvalid, 0);
      chk("mid_ram_we", ram_we, 0);
      tick();
      settle();
      tick(); rst = 1'b0; h_req = 1'b1;
      settle();
      chk("mid_regnt", h_gnt, 1);
      host_q.push_back(32'hA500_0003);
      tick(); h_req = 1'b0;
      settle();
      chk("mid_rvalid2", h_rvalid, 1);
      tick(); h_req = 1'b1; h_we = 1'b1; h_addr = 32'h0000_1004; h_wdata = 32'h1234_5678;
      settle();
      chk("tr_gnt", h_gnt, 1);
      chk("tr_we", ram_we, 1);
      chk("tr_addr", ram_addr, 32'h1);
      tick(); h_req = 1'b0; h_we = 1'b0; cpu_dre = 1'b1; cpu_daddr = 32'h4;
      cpu_q.push_back(32'h1234_5678);
      settle();
      chk("tr_hlt", cpu_hlt, 1);
      tick();
      settle();
      chk("tr_rdata", cpu_rdata, cpu_q.pop_front());
      tick(); cpu_dre = 1'b0; h_req = 1'b1; h_we = 1'b1; h_addr = 32'h0000_1007; h_wdata = 32'hCAFE_F00D;
      settle();
      chk("tr3_addr", ram_addr, 32'h1);
      chk("tr3_we", ram_we, 1);
      tick(); h_req = 1'b0; h_we = 1'b0; cpu_dre = 1'b1; cpu_daddr = 32'h4;
      cpu_q.push_back(32'hCAFE_F00D);
      settle();
      tick();
      settle();
      chk("tr3_rdata", cpu_rdata, cpu_q.pop_front());
      tick(); cpu_dre = 1'b0;
      settle();
      tick();
      settle();
      chk("host_q_empty", 32'(host_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
